// File: rtl/issue_queue_pkg.sv
// Shared widths and the queue entry record for the issue queue.
// Struct field widths follow the default configuration; the top derives its port widths from the same values.
package issue_pkg;
    localparam int IQ_DEPTH   = 8;
    localparam int IQ_REG_NUM = 16;
    localparam int IQ_OPC_W   = 4;
    localparam int IQ_DES_W   = $clog2(IQ_REG_NUM);
    localparam int IQ_SRC_W   = $clog2(IQ_REG_NUM);
    localparam int IQ_IMM_W   = 4;
    localparam int IQ_BR_W    = 3;

    typedef struct packed {
        logic                valid;
        logic [IQ_OPC_W-1:0] opc;
        logic [IQ_DES_W-1:0] des;
        logic [IQ_SRC_W-1:0] src1;
        logic [IQ_SRC_W-1:0] src2;
        logic                rdy1;
        logic                rdy2;
        logic [IQ_IMM_W-1:0] imm;
        logic [IQ_BR_W-1:0]  br;
    } entry_t;
endpackage

// File: rtl/issue_queue_if.sv
// Dispatch, writeback, squash, issue and status bundle of the issue queue.
// master = surrounding pipeline, slave = the queue.
interface issue_queue_if import issue_pkg::*; #(
    parameter int DEPTH = IQ_DEPTH,
    parameter int OPC_W = IQ_OPC_W,
    parameter int DES_W = IQ_DES_W,
    parameter int SRC_W = IQ_SRC_W,
    parameter int IMM_W = IQ_IMM_W,
    parameter int BR_W  = IQ_BR_W
) ();
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             in_valid;
    logic             in_ready;
    logic [OPC_W-1:0] in_opc;
    logic [DES_W-1:0] in_des;
    logic [SRC_W-1:0] in_src1;
    logic [SRC_W-1:0] in_src2;
    logic [IMM_W-1:0] in_imm;
    logic [BR_W-1:0]  in_br;
    logic             wb_valid;
    logic [DES_W-1:0] wb_des;
    logic             sq_valid;
    logic [BR_W-1:0]  sq_br;
    logic             iss_valid;
    logic             iss_ready;
    logic [OPC_W-1:0] iss_opc;
    logic [DES_W-1:0] iss_des;
    logic [SRC_W-1:0] iss_src1;
    logic [SRC_W-1:0] iss_src2;
    logic [IMM_W-1:0] iss_imm;
    logic [BR_W-1:0]  iss_br;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;

    modport master (
        output in_valid, in_opc, in_des, in_src1, in_src2, in_imm, in_br,
               wb_valid, wb_des, sq_valid, sq_br, iss_ready,
        input  in_ready, iss_valid, iss_opc, iss_des, iss_src1, iss_src2, iss_imm, iss_br,
               count, full, empty
    );
    modport slave (
        input  in_valid, in_opc, in_des, in_src1, in_src2, in_imm, in_br,
               wb_valid, wb_des, sq_valid, sq_br, iss_ready,
        output in_ready, iss_valid, iss_opc, iss_des, iss_src1, iss_src2, iss_imm, iss_br,
               count, full, empty
    );
endinterface

// File: rtl/issue_queue_age_select.sv
// Lowest-index-wins picker: one-hot grant, binary index and any-grant from a request vector.
// Purely combinational, no state.
module age_select #(
    parameter int N     = 8,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                gnt    = '0;
                gnt[i] = 1'b1;
                idx    = IDX_W'(i);
                any    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/issue_queue.sv
// Age-ordered compacting issue queue with register scoreboard, writeback wakeup and branch-tag squash.
// Dispatch-to-issue 1 cycle; in_ready = !full (a same-cycle issue does not free a slot), issue held until iss_ready.
module issue_queue import issue_pkg::*; #(
    parameter int DEPTH   = IQ_DEPTH,
    parameter int REG_NUM = IQ_REG_NUM,
    parameter int OPC_W   = IQ_OPC_W,
    parameter int DES_W   = IQ_DES_W,
    parameter int SRC_W   = IQ_SRC_W,
    parameter int IMM_W   = IQ_IMM_W,
    parameter int BR_W    = IQ_BR_W
) (
    input logic          clk,
    input logic          rst_n,
    issue_queue_if.slave bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    entry_t             q   [DEPTH];
    entry_t             q_n [DEPTH];
    logic [REG_NUM-1:0] busy, busy_n;
    logic [CNT_W-1:0]   count_r, count_n;
    logic               full_r, empty_r;

    logic [DEPTH-1:0]   req, gnt, sq_hit;
    logic [IDX_W-1:0]   sel_idx;
    logic               sel_any, fire, accept, app;

    logic [OPC_W-1:0]   d_opc;
    logic [DES_W-1:0]   d_des;
    logic [SRC_W-1:0]   d_src1, d_src2;
    logic [IMM_W-1:0]   d_imm;
    logic [BR_W-1:0]    d_br;

    assign d_opc  = bus.in_opc;
    assign d_des  = bus.in_des;
    assign d_src1 = bus.in_src1;
    assign d_src2 = bus.in_src2;
    assign d_imm  = bus.in_imm;
    assign d_br   = bus.in_br;

    always_comb begin
        sq_hit = '0;
        req    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            sq_hit[i] = bus.sq_valid && q[i].valid && (q[i].br == bus.sq_br);
            req[i]    = q[i].valid && q[i].rdy1 && q[i].rdy2 && !sq_hit[i];
        end
    end

    age_select #(.N(DEPTH), .IDX_W(IDX_W)) u_age_select (
        .req (req),
        .gnt (gnt),
        .idx (sel_idx),
        .any (sel_any)
    );

    assign bus.iss_valid = sel_any;
    assign bus.iss_opc   = sel_any ? q[sel_idx].opc  : '0;
    assign bus.iss_des   = sel_any ? q[sel_idx].des  : '0;
    assign bus.iss_src1  = sel_any ? q[sel_idx].src1 : '0;
    assign bus.iss_src2  = sel_any ? q[sel_idx].src2 : '0;
    assign bus.iss_imm   = sel_any ? q[sel_idx].imm  : '0;
    assign bus.iss_br    = sel_any ? q[sel_idx].br   : '0;

    assign fire   = sel_any && bus.iss_ready;
    assign accept = bus.in_valid && !full_r;
    // A dispatch carrying the tag being squashed is consumed but never enters the queue.
    assign app    = accept && !(bus.sq_valid && (d_br == bus.sq_br));

    always_comb begin
        logic keep;
        q_n     = '{default: '0};
        busy_n  = busy;
        count_n = '0;
        keep    = 1'b0;

        for (int i = 0; i < DEPTH; i++) begin
            if (q[i].valid && !sq_hit[i] && !(fire && gnt[i])) begin
                q_n[count_n[IDX_W-1:0]] = q[i];
                count_n = count_n + CNT_W'(1);
            end
        end

        // A squashed dest stays busy if any non-squashed producer (queued, issuing or dispatching) targets it.
        for (int i = 0; i < DEPTH; i++) begin
            if (sq_hit[i]) begin
                keep = app && (d_des == q[i].des);
                for (int j = 0; j < DEPTH; j++) begin
                    if (q[j].valid && !sq_hit[j] && (q[j].des == q[i].des)) keep = 1'b1;
                end
                if (!keep) busy_n[q[i].des] = 1'b0;
            end
        end

        if (bus.wb_valid) busy_n[bus.wb_des] = 1'b0;

        if (app) begin
            q_n[count_n[IDX_W-1:0]].valid = 1'b1;
            q_n[count_n[IDX_W-1:0]].opc   = d_opc;
            q_n[count_n[IDX_W-1:0]].des   = d_des;
            q_n[count_n[IDX_W-1:0]].src1  = d_src1;
            q_n[count_n[IDX_W-1:0]].src2  = d_src2;
            q_n[count_n[IDX_W-1:0]].imm   = d_imm;
            q_n[count_n[IDX_W-1:0]].br    = d_br;
            q_n[count_n[IDX_W-1:0]].rdy1  = (d_src1 == '0) || !busy[d_src1] ||
                                            (bus.wb_valid && (bus.wb_des == d_src1));
            q_n[count_n[IDX_W-1:0]].rdy2  = (d_src2 == '0) || !busy[d_src2] ||
                                            (bus.wb_valid && (bus.wb_des == d_src2));
            count_n = count_n + CNT_W'(1);
            if (d_des != '0) busy_n[d_des] = 1'b1;
        end

        for (int i = 0; i < DEPTH; i++) begin
            if (q_n[i].valid && bus.wb_valid) begin
                if (q_n[i].src1 == bus.wb_des) q_n[i].rdy1 = 1'b1;
                if (q_n[i].src2 == bus.wb_des) q_n[i].rdy2 = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q       <= '{default: '0};
            busy    <= '0;
            count_r <= '0;
            full_r  <= 1'b0;
            empty_r <= 1'b1;
        end else begin
            q       <= q_n;
            busy    <= busy_n;
            count_r <= count_n;
            full_r  <= (count_n == CNT_W'(DEPTH));
            empty_r <= (count_n == '0);
        end
    end

    assign bus.count    = count_r;
    assign bus.full     = full_r;
    assign bus.empty    = empty_r;
    assign bus.in_ready = !full_r;
endmodule

// File: tb/tb_issue_queue.sv
// Bench for issue_queue: directed scenarios with literal expectations, then randomized traffic,
// all compared every cycle against a queue-based reference model.
module tb_issue_queue;
    import issue_pkg::*;

    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    issue_queue_if #(.DEPTH(DEPTH)) bus ();

    issue_queue #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] opc, des, src1, src2, imm;
        logic [2:0] br;
        bit         r1, r2;
    } m_ent_t;

    m_ent_t    mq[$];
    bit [15:0] mbusy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_sel();
        for (int i = 0; i < mq.size(); i++)
            if (mq[i].r1 && mq[i].r2 && !(bus.sq_valid && mq[i].br == bus.sq_br)) return i;
        return -1;
    endfunction

    function automatic bit src_rdy(input logic [3:0] s);
        return (s == 0) || !mbusy[s] || (bus.wb_valid && bus.wb_des == s);
    endfunction

    task automatic compare();
        int s;
        s = m_sel();
        chk("iss_valid", bus.iss_valid, (s >= 0));
        if (s >= 0)
            chk("iss_bundle", {bus.iss_opc, bus.iss_des, bus.iss_src1, bus.iss_src2, bus.iss_imm, bus.iss_br},
                {mq[s].opc, mq[s].des, mq[s].src1, mq[s].src2, mq[s].imm, mq[s].br});
        if (!rst_n)
            chk("iss_zero_in_reset", {bus.iss_opc, bus.iss_des, bus.iss_src1, bus.iss_src2, bus.iss_imm, bus.iss_br}, 0);
        chk("count", bus.count, mq.size());
        chk("full", bus.full, (mq.size() == DEPTH));
        chk("empty", bus.empty, (mq.size() == 0));
        chk("in_ready", bus.in_ready, (mq.size() != DEPTH));
    endtask

    task automatic model_update();
        int         s;
        bit         fire, acc, app, shared;
        m_ent_t     ne;
        m_ent_t     nq[$];
        logic [3:0] sqd[$];
        logic [3:0] srv[$];
        if (!rst_n) begin
            mq.delete();
            mbusy = '0;
            return;
        end
        s    = m_sel();
        fire = (s >= 0) && bus.iss_ready;
        acc  = bus.in_valid && (mq.size() < DEPTH);
        app  = acc && !(bus.sq_valid && bus.in_br == bus.sq_br);
        ne.opc = bus.in_opc; ne.des = bus.in_des; ne.src1 = bus.in_src1; ne.src2 = bus.in_src2;
        ne.imm = bus.in_imm; ne.br = bus.in_br;
        ne.r1 = src_rdy(bus.in_src1);
        ne.r2 = src_rdy(bus.in_src2);
        foreach (mq[i]) begin
            if (bus.sq_valid && mq[i].br == bus.sq_br) sqd.push_back(mq[i].des);
            else begin
                srv.push_back(mq[i].des);
                if (!(fire && i == s)) nq.push_back(mq[i]);
            end
        end
        if (app) srv.push_back(bus.in_des);
        foreach (sqd[k]) begin
            shared = 0;
            foreach (srv[j]) if (srv[j] == sqd[k]) shared = 1;
            if (!shared) mbusy[sqd[k]] = 1'b0;
        end
        if (bus.wb_valid) mbusy[bus.wb_des] = 1'b0;
        if (app && bus.in_des != 0) mbusy[bus.in_des] = 1'b1;
        if (app) nq.push_back(ne);
        if (bus.wb_valid)
            foreach (nq[i]) begin
                if (nq[i].src1 == bus.wb_des) nq[i].r1 = 1;
                if (nq[i].src2 == bus.wb_des) nq[i].r2 = 1;
            end
        mq = nq;
    endtask

    // Called at a falling edge with inputs already applied.
    task automatic cycle();
        #1;
        compare();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        bus.in_valid = 0; bus.in_opc = 0; bus.in_des = 0; bus.in_src1 = 0; bus.in_src2 = 0;
        bus.in_imm = 0; bus.in_br = 0; bus.wb_valid = 0; bus.wb_des = 0; bus.sq_valid = 0; bus.sq_br = 0;
    endtask

    task automatic disp(input logic [3:0] opc, des, s1, s2, input logic [2:0] br);
        idle();
        bus.in_valid = 1; bus.in_opc = opc; bus.in_des = des; bus.in_src1 = s1; bus.in_src2 = s2;
        bus.in_imm = 4'($urandom); bus.in_br = br;
    endtask

    initial begin
        idle();
        bus.iss_ready = 0;
        mbusy = '0;
        @(negedge clk);
        cycle();
        cycle();
        settle();
        chk("rst_count", bus.count, 0);
        chk("rst_empty", bus.empty, 1);
        chk("rst_full", bus.full, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_iss_valid", bus.iss_valid, 0);
        chk("rst_iss_opc", bus.iss_opc, 0);
        rst_n = 1;

        // Independent stream
        bus.iss_ready = 1;
        disp(1, 0, 0, 0, 0); cycle();
        disp(2, 0, 0, 0, 0); settle(); chk("ind_a", bus.iss_opc, 1); chk("ind_cnt1", bus.count, 1); cycle();
        disp(3, 0, 0, 0, 0); settle(); chk("ind_b", bus.iss_opc, 2); chk("ind_cnt2", bus.count, 1); cycle();
        idle(); settle(); chk("ind_c", bus.iss_opc, 3); chk("ind_cnt3", bus.count, 1); cycle();
        settle(); chk("ind_empty", bus.empty, 1);

        // Dependency through r5
        disp(4, 5, 0, 0, 0); cycle();
        disp(5, 0, 5, 0, 0); settle(); chk("dep_a", bus.iss_opc, 4); cycle();
        idle();
        repeat (3) begin settle(); chk("dep_wait", bus.iss_valid, 0); cycle(); end
        bus.wb_valid = 1; bus.wb_des = 5; settle(); chk("dep_pre_wb", bus.iss_valid, 0); cycle();
        idle(); settle(); chk("dep_wake_v", bus.iss_valid, 1); chk("dep_wake_opc", bus.iss_opc, 5); cycle();

        // Out-of-order issue around a busy r3
        disp(6, 3, 0, 0, 0); cycle();
        disp(7, 0, 3, 0, 0); settle(); chk("ooo_x", bus.iss_opc, 6); cycle();
        disp(8, 0, 0, 0, 0); settle(); chk("ooo_blocked", bus.iss_valid, 0); cycle();
        idle(); settle(); chk("ooo_cnt2", bus.count, 2); chk("ooo_b_first", bus.iss_opc, 8); cycle();
        settle(); chk("ooo_cnt1", bus.count, 1); chk("ooo_a_wait", bus.iss_valid, 0);
        bus.wb_valid = 1; bus.wb_des = 3; cycle();
        idle(); settle(); chk("ooo_a_issue", bus.iss_opc, 7); cycle();
        settle(); chk("ooo_cnt0", bus.count, 0);

        // Fill to full, then a same-cycle issue must not admit a dispatch
        bus.iss_ready = 0;
        for (int i = 0; i < DEPTH; i++) begin disp(4'(i), 0, 0, 0, 0); cycle(); end
        disp(15, 0, 0, 0, 0); settle();
        chk("full_flag", bus.full, 1); chk("full_rdy", bus.in_ready, 0); chk("full_cnt", bus.count, DEPTH);
        cycle();
        bus.iss_ready = 1; settle(); chk("full_still", bus.count, DEPTH); chk("full_head", bus.iss_opc, 0); cycle();
        idle(); settle(); chk("full_freed", bus.count, DEPTH - 1); chk("full_clear", bus.full, 0);
        repeat (DEPTH) cycle();

        // Squash tag 1 out of tags 1,2,1,3
        bus.iss_ready = 0;
        disp(1, 9, 0, 0, 1);  cycle();
        disp(2, 10, 0, 0, 2); cycle();
        disp(3, 11, 0, 0, 1); cycle();
        disp(4, 12, 0, 0, 3); cycle();
        idle(); bus.sq_valid = 1; bus.sq_br = 1; settle();
        chk("sq_cnt_before", bus.count, 4); chk("sq_skip_head", bus.iss_opc, 2); cycle();
        idle(); settle(); chk("sq_cnt_after", bus.count, 2);
        disp(5, 0, 9, 0, 0); cycle();
        idle(); bus.iss_ready = 1; settle(); chk("sq_order0", bus.iss_opc, 2); cycle();
        settle(); chk("sq_order1", bus.iss_opc, 4); cycle();
        settle(); chk("sq_freed_dest", bus.iss_opc, 5);
        disp(6, 0, 10, 0, 0); cycle();
        idle(); settle(); chk("sq_kept_busy", bus.iss_valid, 0);
        bus.wb_valid = 1; bus.wb_des = 10; cycle();
        idle(); settle(); chk("sq_kept_wake", bus.iss_opc, 6); cycle();

        // Dispatch and writeback of r7 in the same cycle
        disp(9, 7, 0, 0, 0); cycle();
        disp(10, 0, 7, 0, 0); bus.wb_valid = 1; bus.wb_des = 7; settle(); chk("col_prod", bus.iss_opc, 9); cycle();
        idle(); settle(); chk("col_v", bus.iss_valid, 1); chk("col_opc", bus.iss_opc, 10); cycle();

        // Mid-stream reset
        bus.iss_ready = 0;
        disp(11, 0, 0, 0, 0); cycle();
        disp(12, 0, 0, 0, 0); cycle();
        idle(); settle(); chk("pre_rst_v", bus.iss_valid, 1);
        rst_n = 0; mq.delete(); mbusy = '0; settle();
        chk("mid_rst_empty", bus.empty, 1); chk("mid_rst_v", bus.iss_valid, 0); chk("mid_rst_cnt", bus.count, 0);
        cycle();
        rst_n = 1;

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            idle();
            bus.in_valid  = ($urandom_range(0, 99) < 60);
            bus.in_opc    = 4'($urandom);
            bus.in_des    = 4'($urandom_range(0, 7));
            bus.in_src1   = 4'($urandom_range(0, 7));
            bus.in_src2   = 4'($urandom_range(0, 7));
            bus.in_imm    = 4'($urandom);
            bus.in_br     = 3'($urandom_range(0, 3));
            bus.wb_valid  = ($urandom_range(0, 99) < 35);
            bus.wb_des    = 4'($urandom_range(0, 7));
            bus.sq_valid  = ($urandom_range(0, 99) < 6);
            bus.sq_br     = 3'($urandom_range(0, 3));
            bus.iss_ready = ($urandom_range(0, 99) < 70);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
